even_odd_count_sched: RTL and testbench
=======================================

# even_odd_count_sched

Two-requester scheduler for the `even_odd_counter` datapath. It arbitrates round-robin between two clients that each want a counting run, then sequences the counter through load and run phases. Each run is defined by a start value, a mode (even/odd) and a run length. When the run finishes, the scheduler returns the final count to the granted client. It sits between the client logic and one shared `even_odd_counter` instance and is the only driver of that counter's `load`, `mode` and `data_in`.

## Interface
- `WIDTH`, 4: counter data width; must match the attached counter.
- `LEN_W`, 4: run-length field width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  2  per-client request; hold high until the matching `gnt` bit is seen.
- `req_mode`  in  2  per-client mode; 0 = even, 1 = odd.
- `req_data`  in  2*WIDTH  per-client start value; client 0 in the low slice.
- `req_len`  in  2*LEN_W  per-client run length in counter steps; client 0 in the low slice.
- `gnt`  out  2  one-cycle pulse, one-hot, when the request is accepted.
- `done`  out  2  one-cycle pulse, one-hot, when the result is valid.
- `result`  out  WIDTH  final count of the last completed run; held until the next `done`.
- `busy`  out  1  high in every state except IDLE.
- `cnt_load`  out  1  drives counter `load`.
- `cnt_mode`  out  1  drives counter `mode`.
- `cnt_data`  out  WIDTH  drives counter `data_in`.
- `cnt_count`  in  WIDTH  counter `count` output.

## Operation
- The FSM has four states: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - If any `req` bit is high, the arbiter picks a winner.
  - The winner's mode, data, len and id are latched, and the FSM goes to LOAD.
  - If no `req` bit is high, the FSM stays in IDLE.
- **LOAD** (exactly 1 cycle)
  - `cnt_load`=1, `cnt_mode`/`cnt_data` = latched values, `gnt[id]`=1.
  - If len==0, next state is DONE; otherwise remaining=len and next state is RUN.
- **RUN**
  - `cnt_load`=0 and remaining decrements every cycle.
  - When remaining==1, next state is DONE, so RUN lasts exactly len cycles.
- **DONE** (1 cycle)
  - `result` <= `cnt_count` at the exit edge.
  - `done[id]` is registered high in the following cycle, which is IDLE.
  - Next state is IDLE.
- **Arbitration**
  - Round-robin over 2 clients using a last-served pointer; after reset, client 0 has priority.
  - When both clients request in the same IDLE cycle, the client not served last wins.
  - The loser stays pending and is served in the next IDLE cycle.
- **Request and hold rules**
  - A request still high in the IDLE cycle after its `done` counts as a new request.
  - `req` is ignored in every state except IDLE.
  - `cnt_mode`/`cnt_data` hold their last values outside LOAD.
  - `cnt_load` is 0 in every state except LOAD.
- **Arithmetic**
  - Counter arithmetic is modulo 2^WIDTH. The scheduler does no arithmetic on counts; it only samples them.
  - The expected result is (data + 2*len) mod 2^WIDTH.
- **Reset**
  - `rst` low forces IDLE and clears the pointer, `gnt`, `done`, `result`, `busy`, `cnt_load`, `cnt_mode` and `cnt_data` to 0.
  - Reset mid-run aborts the run: no `done` is issued and the client must re-request.

## Timing
- Request sampled at edge E0 (in IDLE):
  - cycle 1 = LOAD (`gnt` and `cnt_load` high; counter loads at E1);
  - cycles 2..len+1 = RUN;
  - cycle len+2 = DONE;
  - cycle len+3 = `done` pulse, `result` valid, FSM in IDLE.
- Request-to-done latency is len+3 cycles.
- For len==0, `done` arrives in cycle 3 and `result`=data.
- `busy` rises in cycle 1 and falls in cycle len+3.
- A new request can be accepted at the end of the `done` cycle, which is back-to-back service.
- All outputs are registered except `busy`, which is decoded from state.

## Structure
- Package `even_odd_sched_pkg` holds:
  - the state typedef (IDLE=0, LOAD=1, RUN=2, DONE=3);
  - the mode constants MODE_EVEN=0 and MODE_ODD=1;
  - the client count constant NUM_CLIENTS=2.
- Sub-module `rr_arb2` implements the 2-way round-robin arbiter:
  - inputs: `req[1:0]`, `en`, `clk`, `rst`;
  - outputs: one-hot `win`;
  - it updates its pointer when `en`=1 and a winner exists.
- The top level holds the FSM, the run-length counter and the latches.
- The bench instantiates the real `even_odd_counter` as the datapath.

## Test plan
- Reset, then client 0 with mode 0, data 2, len 3 -> `gnt`=01 in cycle 1, `done`=01 in cycle 6, `result`=8.
- Client 1 with mode 1, data 3, len 2 -> `gnt`=10, `result`=7, latency 5 cycles.
- Both clients requesting in the same cycle after reset -> client 0 served first, client 1 granted in the cycle after the first `done`, then client 0 again if still requesting; grants strictly alternate.
- Mode 0, data 14, len 2 -> `result`=2 (wrap); len 0 with data 9 -> `result`=9 and `done` in cycle 3.
- Assert `rst` low during RUN -> all outputs 0 immediately, no `done`; after release, a new request completes normally.
- `req` toggled during RUN/DONE -> ignored; `cnt_load` is high in exactly one cycle per run.

Source files
------------

// File: rtl/even_odd_sched_pkg.sv
// even_odd_sched_pkg
// Shared definitions for the even/odd counter scheduler slice:
//   - state_t and its four state constants (IDLE, LOAD, RUN, DONE)
//   - counter mode constants (MODE_EVEN, MODE_ODD)
//   - number of clients served by the scheduler (NUM_CLIENTS)
package even_odd_sched_pkg;

  // States are plain constants over a 2-bit type so older tools that
  // dislike enums in ports and case labels still accept them.
  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t RUN  = 2'd2;
  localparam state_t DONE = 2'd3;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  localparam int NUM_CLIENTS = 2;

endpackage

// File: rtl/even_odd_count_sched_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter.
// When both clients request, the client that was not served last wins.
// After reset, client 0 holds the tie-break priority.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-low reset
//   req  in   per-client request
//   en   in   a winner is being consumed this cycle; advance the pointer
//   win  out  one-hot winner (0 when nobody requests)
module rr_arb2
  import even_odd_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   en,
  output logic [NUM_CLIENTS-1:0] win
);

  // prio names the client that wins a tie.
  logic prio;

  always_comb begin
    win = '0;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = prio ? 2'b10 : 2'b01;
      default: win = '0;
    endcase
  end

  // After serving a client, the tie-break passes to the other client.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio <= 1'b0;
    end else if (en && (|win)) begin
      prio <= ~win[1];
    end
  end

endmodule

// File: rtl/even_odd_counter.sv
// even_odd_counter
// Counter datapath stepped through even or odd values.
// The counter loads data_in when load is high. Otherwise it moves to the
// next value whose parity matches mode. If the current value already has
// that parity, the step is +2. If it does not, a +1 step re-aligns it.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   load     in   load data_in this cycle
//   mode     in   0 = even values, 1 = odd values
//   data_in  in   WIDTH-bit load value
//   count    out  WIDTH-bit current count (wraps modulo 2^WIDTH)
module even_odd_counter
  import even_odd_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= data_in;
    end else if (count[0] == mode) begin
      count <= count + WIDTH'(2);
    end else begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/even_odd_count_sched.sv
// even_odd_count_sched
// Scheduler for two clients sharing one even_odd_counter.
// It grants one client round-robin and loads that client's start value and
// mode into the counter. It then lets the counter run for the requested
// number of steps and returns the final count together with a done pulse.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   req        in   per-client request, held until gnt is seen
//   req_mode   in   per-client mode (0 even, 1 odd)
//   req_data   in   per-client start value, client 0 in the low slice
//   req_len    in   per-client run length, client 0 in the low slice
//   gnt        out  one-hot grant pulse, issued in the LOAD cycle
//   done       out  one-hot completion pulse, issued in the IDLE cycle after DONE
//   result     out  final count of the last completed run
//   busy       out  high whenever the FSM is not IDLE
//   cnt_load   out  counter load strobe
//   cnt_mode   out  counter mode
//   cnt_data   out  counter load value
//   cnt_count  in   counter current value
module even_odd_count_sched
  import even_odd_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CLIENTS-1:0]       req,
  input  logic [NUM_CLIENTS-1:0]       req_mode,
  input  logic [2*WIDTH-1:0]           req_data,
  input  logic [2*LEN_W-1:0]           req_len,
  output logic [NUM_CLIENTS-1:0]       gnt,
  output logic [NUM_CLIENTS-1:0]       done,
  output logic [WIDTH-1:0]             result,
  output logic                         busy,
  output logic                         cnt_load,
  output logic                         cnt_mode,
  output logic [WIDTH-1:0]             cnt_data,
  input  logic [WIDTH-1:0]             cnt_count
);

  state_t               state;
  logic                 id_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     remaining;
  logic [NUM_CLIENTS-1:0] win;

  logic                 sel_mode;
  logic [WIDTH-1:0]     sel_data;
  logic [LEN_W-1:0]     sel_len;

  // The arbiter pointer only advances in IDLE, when a grant is taken.
  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (state == IDLE),
    .win (win)
  );

  // Pick the winning client's fields out of the packed request buses.
  always_comb begin
    sel_mode = win[1] ? req_mode[1] : req_mode[0];
    sel_data = win[1] ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
    sel_len  = win[1] ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
  end

  assign busy = (state != IDLE);

  // Main sequencer. gnt, done and cnt_load are single-cycle pulses that
  // default low. cnt_mode and cnt_data keep their last loaded values so
  // the counter inputs do not move between runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      id_q      <= 1'b0;
      len_q     <= '0;
      remaining <= '0;
      gnt       <= '0;
      done      <= '0;
      result    <= '0;
      cnt_load  <= 1'b0;
      cnt_mode  <= 1'b0;
      cnt_data  <= '0;
    end else begin
      gnt      <= '0;
      done     <= '0;
      cnt_load <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= LOAD;
            id_q     <= win[1];
            len_q    <= sel_len;
            cnt_mode <= sel_mode;
            cnt_data <= sel_data;
            cnt_load <= 1'b1;
            gnt      <= win;
          end
        end
        LOAD: begin
          if (len_q == '0) begin
            state <= DONE;
          end else begin
            remaining <= len_q;
            state     <= RUN;
          end
        end
        RUN: begin
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          result <= cnt_count;
          done   <= id_q ? 2'b10 : 2'b01;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_even_odd_count_sched.sv
// tb_even_odd_count_sched
// Bench for even_odd_count_sched driving a real even_odd_counter.
// A schedule-level model predicts which client is granted and when, when
// done pulses, and what the result is, using (data + 2*len) mod 16. The
// outputs are compared against it on every falling edge. The directed
// scenarios also check a few hand-computed literal values.
module tb_even_odd_count_sched;
  localparam int WIDTH = 4;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       req = '0;
  logic [1:0]       req_mode = '0;
  logic [2*WIDTH-1:0] req_data = '0;
  logic [2*LEN_W-1:0] req_len = '0;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             cnt_load;
  logic             cnt_mode;
  logic [WIDTH-1:0] cnt_data;
  logic [WIDTH-1:0] cnt_count;

  even_odd_count_sched #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .req_len   (req_len),
    .gnt       (gnt),
    .done      (done),
    .result    (result),
    .busy      (busy),
    .cnt_load  (cnt_load),
    .cnt_mode  (cnt_mode),
    .cnt_data  (cnt_data),
    .cnt_count (cnt_count)
  );

  even_odd_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .mode    (cnt_mode),
    .data_in (cnt_data),
    .count   (cnt_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Schedule model. Cycle n is the interval after the n-th rising edge.
  // A request is accepted at an edge when the scheduler was idle in the
  // previous cycle. The cycle of a done pulse already counts as idle.
  int cyc = 0;
  int free_from = -1;
  int gnt_cyc = -1;
  int done_cyc = -1;
  int m_id = 0;
  int m_prio = 0;
  int w_m = 0;
  int l_m = 0;
  int p_mode = 0;
  int p_data = 0;
  int pend_res = 0;
  int cur_mode = 0;
  int cur_data = 0;
  int cur_res = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst) begin
      free_from = -1;
      gnt_cyc   = -1;
      done_cyc  = -1;
      m_prio    = 0;
    end else if ((cyc - 1) >= free_from && req != 2'b00) begin
      if (req == 2'b11) w_m = m_prio;
      else              w_m = req[1] ? 1 : 0;
      m_prio   = (w_m == 0) ? 1 : 0;
      l_m      = int'(req_len[w_m*LEN_W +: LEN_W]);
      p_mode   = int'(req_mode[w_m]);
      p_data   = int'(req_data[w_m*WIDTH +: WIDTH]);
      pend_res = (p_data + 2*l_m) % 16;
      m_id     = w_m;
      gnt_cyc  = cyc;
      done_cyc = cyc + l_m + 2;
      free_from = done_cyc;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial forever begin
    logic [1:0] exp_oh;
    @(negedge clk);
    if (!rst) begin
      cur_mode = 0; cur_data = 0; cur_res = 0;
      gnt_cyc = -1; done_cyc = -1; free_from = -1;
    end else begin
      if (cyc == gnt_cyc) begin
        cur_mode = p_mode;
        cur_data = p_data;
      end
      if (cyc == done_cyc) cur_res = pend_res;
    end
    exp_oh = (m_id == 0) ? 2'b01 : 2'b10;
    checkOutput("gnt",      32'(gnt),      (cyc == gnt_cyc)  ? 32'(exp_oh) : 32'd0);
    checkOutput("done",     32'(done),     (cyc == done_cyc) ? 32'(exp_oh) : 32'd0);
    checkOutput("busy",     32'(busy),     (gnt_cyc >= 0 && cyc >= gnt_cyc && cyc < done_cyc) ? 32'd1 : 32'd0);
    checkOutput("cnt_load", 32'(cnt_load), (cyc == gnt_cyc) ? 32'd1 : 32'd0);
    checkOutput("cnt_mode", 32'(cnt_mode), 32'(cur_mode));
    checkOutput("cnt_data", 32'(cnt_data), 32'(cur_data));
    checkOutput("result",   32'(result),   32'(cur_res));
  end

  // Raise one client's request and wait for its done.
  // lat counts rising edges from the sampling edge to the done cycle.
  task automatic applyStimulus(input int c, input logic m, input logic [3:0] d,
                               input logic [3:0] l, output int lat, output int gnt_lat,
                               output logic [1:0] g, output logic [3:0] res);
    bit got = 0;
    req_mode[c]          = m;
    req_data[c*WIDTH +: WIDTH] = d;
    req_len[c*LEN_W +: LEN_W]  = l;
    req[c] = 1'b1;
    lat = 0; gnt_lat = -1; g = '0; res = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      #1;
      if (gnt != 2'b00) begin
        gnt_lat = lat;
        g = gnt;
        req[c] = 1'b0;
      end
      if (done[c]) begin
        got = 1;
        res = result;
      end
    end
    if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulseReset();
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  int lat, glat, loads, n_g, g1_cyc, d1_cyc;
  logic [1:0] g;
  logic [3:0] res;
  logic [1:0] order [4];
  bit fin;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Client 0, even, start 2, 3 steps.
    applyStimulus(0, 1'b0, 4'd2, 4'd3, lat, glat, g, res);
    checkOutput("t1_gnt_val", 32'(g), 32'd1);
    checkOutput("t1_gnt_cycle", 32'(glat), 32'd1);
    checkOutput("t1_latency", 32'(lat), 32'd6);
    checkOutput("t1_result", 32'(res), 32'd8);

    // Client 1, odd, start 3, 2 steps.
    applyStimulus(1, 1'b1, 4'd3, 4'd2, lat, glat, g, res);
    checkOutput("t2_gnt_val", 32'(g), 32'd2);
    checkOutput("t2_latency", 32'(lat), 32'd5);
    checkOutput("t2_result", 32'(res), 32'd7);

    // Both clients requesting together right after reset.
    pulseReset();
    req_mode = 2'b10;
    req_data = {4'd5, 4'd4};
    req_len  = {4'd2, 4'd1};
    req      = 2'b11;
    n_g = 0; g1_cyc = -1; d1_cyc = -1; fin = 0;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(negedge clk);
      #1;
      if (gnt != 2'b00 && n_g < 4) begin
        order[n_g] = gnt;
        if (n_g == 1) g1_cyc = i;
        n_g++;
        if (n_g == 4) req = 2'b00;
      end
      if (done != 2'b00 && d1_cyc < 0) d1_cyc = i;
      if (n_g == 4 && done != 2'b00 && !busy && i > g1_cyc + 8) fin = 1;
    end
    checkOutput("rr_grants", 32'(n_g), 32'd4);
    checkOutput("rr_order0", 32'(order[0]), 32'd1);
    checkOutput("rr_order1", 32'(order[1]), 32'd2);
    checkOutput("rr_order2", 32'(order[2]), 32'd1);
    checkOutput("rr_order3", 32'(order[3]), 32'd2);
    checkOutput("rr_back_to_back", 32'(g1_cyc), 32'(d1_cyc + 1));

    // Wrap-around and zero-length runs.
    applyStimulus(0, 1'b0, 4'd14, 4'd2, lat, glat, g, res);
    checkOutput("wrap_result", 32'(res), 32'd2);
    applyStimulus(1, 1'b1, 4'd9, 4'd0, lat, glat, g, res);
    checkOutput("len0_result", 32'(res), 32'd9);
    checkOutput("len0_latency", 32'(lat), 32'd3);

    // Reset during RUN.
    req_mode[0] = 1'b0; req_data[3:0] = 4'd2; req_len[3:0] = 4'd6;
    req[0] = 1'b1;
    for (int i = 0; i < 10 && req[0]; i++) begin
      @(negedge clk);
      #1;
      if (gnt[0]) req[0] = 1'b0;
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cnt_load", 32'(cnt_load), 32'd0);
    checkOutput("rst_cnt_data", 32'(cnt_data), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    applyStimulus(0, 1'b0, 4'd2, 4'd3, lat, glat, g, res);
    checkOutput("post_rst_result", 32'(res), 32'd8);
    checkOutput("post_rst_latency", 32'(lat), 32'd6);

    // Requests toggled while busy must be ignored.
    req_mode = 2'b10; req_data = {4'd1, 4'd6}; req_len = {4'd4, 4'd3};
    req = 2'b10;
    loads = 0; fin = 0; res = '0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      #1;
      if (cnt_load) loads++;
      if (done[1]) begin
        fin = 1;
        res = result;
      end
      if (busy) req = ~req;
      else if (loads > 0) req = 2'b00;
    end
    req = 2'b00;
    checkOutput("toggle_done_seen", 32'(fin), 32'd1);
    checkOutput("toggle_load_count", 32'(loads), 32'd1);
    checkOutput("toggle_result", 32'(res), 32'd9);

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
